// File: rtl/m_dmem_byteen.sv
// Byte-enabled M-stage data memory: masked writes, write-first registered loads
// with sign/zero extension, and a one-cycle write-trace record.
module m_dmem_byteen #(
  parameter int DEPTH_W = 3072,
  parameter int AW      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        MRE,
  input  logic [2:0]  DMRop,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        tr_valid,
  output logic [31:0] tr_pc,
  output logic [31:0] tr_addr,
  output logic [31:0] tr_data
);

  localparam logic [AW:0] DEPTH_L = DEPTH_W[AW:0];

  logic [31:0]   mem_q [DEPTH_W];
  logic [AW-1:0] idx;
  logic          in_range, we, re;
  logic [31:0]   old_word, merged_d;

  logic [31:0] word_q;
  logic [1:0]  off_q;
  logic [2:0]  op_q;
  logic        addr_err_q, tr_valid_q;
  logic [31:0] tr_pc_q, tr_addr_q, tr_data_q;

  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [1:0]  off,
                                           input logic [2:0]  op);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half = off[1] ? w[31:16] : w[15:0];
    case (off)
      2'd0:    byte_v = w[7:0];
      2'd1:    byte_v = w[15:8];
      2'd2:    byte_v = w[23:16];
      default: byte_v = w[31:24];
    endcase
    case (op)
      3'd0:    load_ext = w;
      3'd1:    load_ext = {{16{half[15]}}, half};
      3'd2:    load_ext = {16'h0000, half};
      3'd3:    load_ext = {{24{byte_v[7]}}, byte_v};
      3'd4:    load_ext = {24'h000000, byte_v};
      default: load_ext = '0;
    endcase
  endfunction

  assign idx      = addr[AW+1:2];
  assign in_range = (addr[31:AW+2] == '0) && ({1'b0, idx} < DEPTH_L);
  assign we       = in_range && (byteen != 4'b0000);
  assign re       = in_range && MRE;
  // Out-of-range indices are never used to read the array.
  assign old_word = in_range ? mem_q[idx] : '0;

  always_comb begin
    merged_d = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged_d[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_W; i++) mem_q[i] <= '0;
      word_q     <= '0;
      off_q      <= '0;
      op_q       <= '0;
      addr_err_q <= 1'b0;
      tr_valid_q <= 1'b0;
      tr_pc_q    <= '0;
      tr_addr_q  <= '0;
      tr_data_q  <= '0;
    end else begin
      if (we) begin
        mem_q[idx] <= merged_d;
        tr_pc_q    <= pc;
        tr_addr_q  <= {addr[31:2], 2'b00};
        tr_data_q  <= merged_d;
      end
      tr_valid_q <= we;
      addr_err_q <= (MRE || (byteen != 4'b0000)) && !in_range;
      // A zeroed word extends to 0 for every op, covering out-of-range loads.
      if (MRE) begin
        word_q <= re ? merged_d : '0;
        off_q  <= addr[1:0];
        op_q   <= DMRop;
      end
    end
  end

  assign rdata    = load_ext(word_q, off_q, op_q);
  assign addr_err = addr_err_q;
  assign tr_valid = tr_valid_q;
  assign tr_pc    = tr_pc_q;
  assign tr_addr  = tr_addr_q;
  assign tr_data  = tr_data_q;

endmodule
